// File: rtl/tl_input_conditioner.sv
// tl_input_conditioner
// Synchronises and debounces the raw operator/sensor inputs feeding the
// traffic-light controller. Level inputs (attention, force-red) leave as
// debounced levels; event inputs (preset, preset-add, preferential) leave as
// latched requests held until the controller acknowledges them per bit.
// Internally every raw bit is packed into one vector so that all channels
// share a single synchroniser/debouncer description:
//   bit 0                      attention
//   bits [N:1]                 force_reds
//   bits [2N:N+1]              presets
//   bits [3N:2N+1]             preset_adds
//   bits [4N:3N+1]             preferentials
// The request channels therefore occupy the top 3N bits, in the same order
// as the packed acknowledge and pending vectors.

module tl_input_conditioner #(
  parameter int N_LIGHTS        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                attention_raw,
  input  logic [N_LIGHTS-1:0] presets_raw,
  input  logic [N_LIGHTS-1:0] preset_adds_raw,
  input  logic [N_LIGHTS-1:0] force_reds_raw,
  input  logic [N_LIGHTS-1:0] preferentials_raw,
  input  logic [N_LIGHTS-1:0] preset_acks,
  input  logic [N_LIGHTS-1:0] preset_add_acks,
  input  logic [N_LIGHTS-1:0] preferential_acks,
  output logic                attention,
  output logic [N_LIGHTS-1:0] force_reds,
  output logic [N_LIGHTS-1:0] presets,
  output logic [N_LIGHTS-1:0] preset_adds,
  output logic [N_LIGHTS-1:0] preferentials,
  output logic                overrun
);

  localparam int NB = 1 + 4 * N_LIGHTS;  // all raw bits
  localparam int NR = 3 * N_LIGHTS;      // request-type bits (top of vector)

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    db;
  logic [CNT_W-1:0] cnt [NB];

  logic [NR-1:0]    db_req;
  logic [NR-1:0]    db_q;
  logic [NR-1:0]    rise;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    pending;
  logic             overrun_q;

  assign raw = {preferentials_raw, preset_adds_raw, presets_raw,
                force_reds_raw, attention_raw};
  assign ack = {preferential_acks, preset_add_acks, preset_acks};

  // Two-flop synchroniser for every raw bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // s1 and s2 into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Per-bit debouncer: accept s2 once it has differed from db for
  // DEBOUNCE_CYCLES consecutive edges; any reversion restarts the count.
  // NOTE: the counter array is ordinary flops, not a RAM, so it is cleared
  // by reset along with everything else to discard partial counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising edges of the debounced request channels.
  assign db_req = db[NB-1 -: NR];

  always_comb begin
    rise = db_req & ~db_q;
  end

  // Request latches: a new rise always wins over an acknowledge on the same
  // edge; a rise that lands on an unacknowledged request is counted as lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q      <= '0;
      pending   <= '0;
      overrun_q <= 1'b0;
    end else begin
      db_q    <= db_req;
      pending <= rise | (pending & ~ack);
      if (|(rise & pending & ~ack)) overrun_q <= 1'b1;
    end
  end

  // All outputs come straight from flops; no combinational path from acks.
  assign attention     = db[0];
  assign force_reds    = db[N_LIGHTS:1];
  assign presets       = pending[N_LIGHTS-1:0];
  assign preset_adds   = pending[2*N_LIGHTS-1:N_LIGHTS];
  assign preferentials = pending[3*N_LIGHTS-1:2*N_LIGHTS];
  assign overrun       = overrun_q;

endmodule
